// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers for the 5-stage core.
//
// Captures the EX-stage instruction into EX/MEM and MEM/WB, issues loads to
// data memory, and produces the pipeline stall. The forwarding unit cannot
// cover load-use hazards or outstanding loads, so both cases stall here.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ex_*                  EX-stage instruction (valid, rd, regwrite, memread, result)
//   idex_rs1, idex_rs2    sources of the instruction currently in EX
//   flush                 kill the EX instruction (branch redirect)
//   dmem_req/addr         load request and address to data memory
//   dmem_ready/rdata      load data valid this cycle, load data
//   exmem_write/rd/data   forwardable EX/MEM register write (never a load)
//   memwb_write/rd/data   MEM/WB register-file write port
//   stall                 hold PC, IF/ID and ID/EX this cycle
//   stall_cnt             saturating count of stalled cycles
//
// Optional feature: define MEM_WB_STALL_CNT_EN to build the stall counter;
// without it stall_cnt is tied to 0 and no counter register exists.
//
// Handshake: dmem_req is held high with a stable dmem_addr until a cycle in
// which dmem_ready is also high; that cycle transfers dmem_rdata. dmem_ready
// is ignored in any cycle where dmem_req is low.

module mem_wb_pipe #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [RA_W-1:0]  idex_rs1,
    input  logic [RA_W-1:0]  idex_rs2,
    input  logic             flush,
    output logic             dmem_req,
    output logic [XLEN-1:0]  dmem_addr,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             exmem_write,
    output logic [RA_W-1:0]  exmem_rd,
    output logic [XLEN-1:0]  exmem_data,
    output logic             memwb_write,
    output logic [RA_W-1:0]  memwb_rd,
    output logic [XLEN-1:0]  memwb_data,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;

    logic            em_valid;
    logic [RA_W-1:0] em_rd;
    logic            em_regwrite;
    logic            em_memread;
    logic [XLEN-1:0] em_result;

    logic            mem_wait;
    logic            load_use;
    logic            em_bubble;

    // Both states issue the request; WAIT only records that it is outstanding.
    assign dmem_req  = em_valid & em_memread & ((state == ST_RUN) | (state == ST_WAIT));
    assign dmem_addr = em_result;

    assign mem_wait  = dmem_req & ~dmem_ready;

    assign load_use  = em_valid & em_memread & (em_rd != '0) & ex_valid &
                       ((em_rd == idex_rs1) | (em_rd == idex_rs2));

    assign stall     = mem_wait | load_use;

    assign em_bubble = load_use | flush | ~ex_valid;

    // Load addresses are never offered to the forwarding unit as data.
    assign exmem_write = em_valid & em_regwrite & ~em_memread;
    assign exmem_rd    = em_rd;
    assign exmem_data  = em_result;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (dmem_req && !dmem_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (dmem_ready)              state_nxt = ST_RUN;
            default:                              state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // EX/MEM: hold while the load in it waits, otherwise bubble or capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            em_valid    <= 1'b0;
            em_rd       <= '0;
            em_regwrite <= 1'b0;
            em_memread  <= 1'b0;
            em_result   <= '0;
        end else if (mem_wait) begin
            em_valid    <= em_valid;
            em_rd       <= em_rd;
            em_regwrite <= em_regwrite;
            em_memread  <= em_memread;
            em_result   <= em_result;
        end else if (em_bubble) begin
            em_valid    <= 1'b0;
            em_rd       <= '0;
            em_regwrite <= 1'b0;
            em_memread  <= 1'b0;
            em_result   <= '0;
        end else begin
            em_valid    <= 1'b1;
            em_rd       <= ex_rd;
            // x0 is hard-wired; never present a write to it downstream.
            em_regwrite <= ex_regwrite & (ex_rd != '0);
            em_memread  <= ex_memread;
            em_result   <= ex_result;
        end
    end

    // MEM/WB: bubble while waiting; when not waiting a load has its data now.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_write <= 1'b0;
            memwb_rd    <= '0;
            memwb_data  <= '0;
        end else if (mem_wait) begin
            memwb_write <= 1'b0;
            memwb_rd    <= '0;
            memwb_data  <= '0;
        end else begin
            memwb_write <= em_valid & em_regwrite;
            memwb_rd    <= em_rd;
            memwb_data  <= em_memread ? dmem_rdata : em_result;
        end
    end

`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
